// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment map for the seven-segment scan driver.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  localparam seg_t SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h04, 7'h0E
  };

  function automatic seg_t hex_to_seg(input logic [3:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero suppress mask: bit i set when digit i and every higher digit are zero.
// Digit 0 is never suppressed so a zero value still shows a single "0".
module seg7_lz_mask #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   suppress
);

  logic upper_zero;

  always_comb begin
    upper_zero = 1'b1;
    suppress   = '0;
    // Walk from the most significant digit down, carrying "all zero so far".
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero  = upper_zero & (digits[4*i +: 4] == 4'h0);
      suppress[i] = lz_suppress & (i != 0) & upper_zero;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with shadowed
// digit data, per-slot dead time and leading-zero suppression. Outputs are registered.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GHOST_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_suppress,
  output logic [6:0]              CATHODE,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   ANODE
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GHOST_END = CNT_W'(GHOST_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  seg_t                    cathode_q, cathode_d;
  logic                    dp_q, dp_d;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              cur_digit;
  logic                    dark;

  seg7_lz_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lz_mask (
    .digits      (sh_digits_q),
    .lz_suppress (lz_suppress),
    .suppress    (lz_mask)
  );

  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    sh_digits_d = sh_digits_q;
    sh_blank_d  = sh_blank_q;
    sh_dp_d     = sh_dp_q;
    anode_d     = '1;
    cathode_d   = SEG_OFF;
    dp_d        = 1'b1;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (load) begin
      sh_digits_d = digits;
      sh_blank_d  = blank;
      sh_dp_d     = dp_in;
    end

    // Outputs follow the pre-edge counters, so they trail the scan by one cycle.
    cur_digit = sh_digits_q[int'(idx_q)*4 +: 4];
    dark      = sh_blank_q[idx_q] | (cnt_q < GHOST_END) | lz_mask[idx_q];
    if (!dark) begin
      anode_d[idx_q] = 1'b0;
      cathode_d      = hex_to_seg(cur_digit);
      dp_d           = ~sh_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_digits_q <= '0;
      sh_blank_q  <= '0;
      sh_dp_q     <= '0;
      anode_q     <= '1;
      cathode_q   <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_digits_q <= sh_digits_d;
      sh_blank_q  <= sh_blank_d;
      sh_dp_q     <= sh_dp_d;
      anode_q     <= anode_d;
      cathode_q   <= cathode_d;
      dp_q        <= dp_d;
    end
  end

  assign ANODE   = anode_q;
  assign CATHODE = cathode_q;
  assign DP      = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 8-cycle slots, 2 dead cycles).
// A time-based reference model predicts every output edge; tables and sequences probe corners.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int RDIV  = 8;
  localparam int GHOST = 2;
  localparam int FRAME = ND * RDIV;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  dp_in;
  logic        lz_suppress;
  logic [6:0]  CATHODE;
  logic        DP;
  logic [3:0]  ANODE;

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RDIV),
    .GHOST_CYCLES (GHOST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .digits      (digits),
    .blank       (blank),
    .dp_in       (dp_in),
    .lz_suppress (lz_suppress),
    .CATHODE     (CATHODE),
    .DP          (DP),
    .ANODE       (ANODE)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position in the frame since reset release plus shadow copies.
  int          m_pos;
  logic [15:0] m_dig;
  logic [3:0]  m_blank;
  logic [3:0]  m_dp;
  logic [3:0]  prev_anode;

  logic [6:0] seg_ref [16];

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  blk;
    logic [3:0]  dpi;
    logic        lz;
    int          slot;
    logic [3:0]  e_an;
    logic [6:0]  e_cat;
    logic        e_dp;
  } vec_t;

  vec_t vt [17];

  function automatic void check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endfunction

  // One clock edge: predict, sample #1 after the edge, compare, advance the model.
  task automatic tick();
    logic [3:0] e_an;
    logic [6:0] e_cat;
    logic       e_dp;
    int         idx, cnt;
    logic       dark;
    e_an  = 4'hF;
    e_cat = 7'h7F;
    e_dp  = 1'b1;
    if (!reset) begin
      idx  = (m_pos / RDIV) % ND;
      cnt  = m_pos % RDIV;
      dark = m_blank[idx] || (cnt < GHOST) ||
             (lz_suppress && idx > 0 && ((m_dig >> (4 * idx)) == 16'h0));
      if (!dark) begin
        e_an[idx] = 1'b0;
        e_cat     = seg_ref[(m_dig >> (4 * idx)) & 16'hF];
        e_dp      = ~m_dp[idx];
      end
    end
    @(posedge clk);
    #1;
    check("model", {ANODE, CATHODE, DP}, {e_an, e_cat, e_dp});
    n_tests++;
    if (!(ANODE == 4'hF || $countones(~ANODE) == 1) ||
        (ANODE != 4'hF && prev_anode != 4'hF && ANODE != prev_anode)) begin
      n_fail++;
      $display("FAIL anode_invariant at %0t: got %h after %h, expected idle or single low bit with dead gap",
               $time, ANODE, prev_anode);
    end
    prev_anode = ANODE;
    if (reset) begin
      m_pos   = 0;
      m_dig   = '0;
      m_blank = '0;
      m_dp    = '0;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
      if (load) begin
        m_dig   = digits;
        m_blank = blank;
        m_dp    = dp_in;
      end
    end
  endtask

  // Tick until the last output edge reflected frame position target-1; bounded by two frames.
  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (m_pos != target && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    n_tests++;
    if (m_pos != target) begin
      n_fail++;
      $display("FAIL run_to: position %0d, expected %0d", m_pos, target);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
  endtask

  initial begin
    seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h04, 7'h0E};
    vt[0]  = '{16'h3A91, 4'h0, 4'h0, 1'b0, 0, 4'hE, 7'h79, 1'b1};
    vt[1]  = '{16'h3A91, 4'h0, 4'h0, 1'b0, 1, 4'hD, 7'h10, 1'b1};
    vt[2]  = '{16'h3A91, 4'h0, 4'h0, 1'b0, 2, 4'hB, 7'h08, 1'b1};
    vt[3]  = '{16'h3A91, 4'h0, 4'h0, 1'b0, 3, 4'h7, 7'h30, 1'b1};
    vt[4]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 3, 4'hF, 7'h7F, 1'b1};
    vt[5]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 2, 4'hF, 7'h7F, 1'b1};
    vt[6]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 1, 4'hD, 7'h12, 1'b1};
    vt[7]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 0, 4'hE, 7'h40, 1'b1};
    vt[8]  = '{16'h0000, 4'h0, 4'h0, 1'b1, 0, 4'hE, 7'h40, 1'b1};
    vt[9]  = '{16'h0000, 4'h0, 4'h0, 1'b1, 1, 4'hF, 7'h7F, 1'b1};
    vt[10] = '{16'h0000, 4'h0, 4'h0, 1'b0, 3, 4'h7, 7'h40, 1'b1};
    vt[11] = '{16'h3A91, 4'h4, 4'h2, 1'b0, 2, 4'hF, 7'h7F, 1'b1};
    vt[12] = '{16'h3A91, 4'h4, 4'h2, 1'b0, 1, 4'hD, 7'h10, 1'b0};
    vt[13] = '{16'h3A91, 4'h4, 4'h2, 1'b0, 0, 4'hE, 7'h79, 1'b1};
    vt[14] = '{16'hBCDE, 4'h0, 4'h0, 1'b0, 0, 4'hE, 7'h04, 1'b1};
    vt[15] = '{16'hBCDE, 4'h0, 4'h0, 1'b0, 2, 4'hB, 7'h27, 1'b1};
    vt[16] = '{16'hBCDE, 4'h0, 4'h0, 1'b0, 3, 4'h7, 7'h03, 1'b1};

    reset       = 1'b1;
    load        = 1'b0;
    digits      = '0;
    blank       = '0;
    dp_in       = '0;
    lz_suppress = 1'b0;
    m_pos       = 0;
    m_dig       = '0;
    m_blank     = '0;
    m_dp        = '0;
    prev_anode  = 4'hF;

    // Reset mid-scan: run a bit, then hold reset 3 cycles.
    do_reset(2);
    for (int i = 0; i < 13; i++) tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", {ANODE, CATHODE, DP}, {4'hF, 7'h7F, 1'b1});
    end
    reset = 1'b0;
    tick();
    check("post_reset_dark0", {8'h0, ANODE}, {8'h0, 4'hF});
    tick();
    check("post_reset_dark1", {8'h0, ANODE}, {8'h0, 4'hF});
    tick();
    check("post_reset_first_lit", {1'b0, ANODE, CATHODE}, {1'b0, 4'hE, 7'h40});

    // Table-driven slot probes.
    for (int v = 0; v < 17; v++) begin
      do_reset(2);
      digits      = vt[v].dig;
      blank       = vt[v].blk;
      dp_in       = vt[v].dpi;
      lz_suppress = vt[v].lz;
      load        = 1'b1;
      tick();
      load = 1'b0;
      run_to((vt[v].slot * RDIV + 5) % FRAME);
      check($sformatf("vec%0d", v), {ANODE, CATHODE, DP}, {vt[v].e_an, vt[v].e_cat, vt[v].e_dp});
    end

    // Full-frame scan with dead-time counting on 3A91.
    do_reset(2);
    digits = 16'h3A91; blank = '0; dp_in = '0; lz_suppress = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    run_to(0);
    begin
      int lit_cnt [4];
      int dark_cnt;
      lit_cnt  = '{0, 0, 0, 0};
      dark_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
        tick();
        if (ANODE == 4'hF) dark_cnt++;
        for (int d = 0; d < 4; d++) if (ANODE == ~(4'b1 << d)) lit_cnt[d]++;
      end
      check("frame_dark_edges", 12'(dark_cnt), 12'(ND * GHOST));
      for (int d = 0; d < 4; d++)
        check($sformatf("frame_lit_digit%0d", d), 12'(lit_cnt[d]), 12'(RDIV - GHOST));
    end

    // Shadowing: input changes without load are invisible; load shows up next edge.
    do_reset(2);
    digits = 16'h1234;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    digits = 16'hFFFF;
    run_to(5);
    check("shadow_digit0", {5'h0, CATHODE}, {5'h0, 7'h19});
    run_to(29);
    check("shadow_digit3", {5'h0, CATHODE}, {5'h0, 7'h79});
    load = 1'b1;
    tick();
    check("load_edge_old_value", {5'h0, CATHODE}, {5'h0, 7'h79});
    load = 1'b0;
    tick();
    check("load_next_edge_new", {5'h0, CATHODE}, {5'h0, 7'h0E});

    // Random stimulus against the model, with occasional resets and lz toggles.
    for (int i = 0; i < 10000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      load  = ($urandom_range(0, 15) == 0);
      for (int d = 0; d < 4; d++)
        digits[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) lz_suppress = ~lz_suppress;
      tick();
    end
    reset = 1'b0;
    load  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode seven-segment display. It captures a packed vector of 4-bit hex nibbles plus per-digit blank and decimal-point flags into shadow registers on a load strobe. It then scans the digits one at a time at a programmable refresh rate, with an anti-ghosting dead time and optional leading-zero suppression. It sits between the game/score logic and the board's CATHODE/ANODE/DP pins, replacing per-digit static decoders.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 100000, clock cycles each digit is selected (≥2).
- GHOST_CYCLES, 1000, cycles at the start of each digit slot with all anodes off (0 ≤ GHOST_CYCLES < REFRESH_DIV).
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture digits/blank/dp_in into shadow registers on this edge.
- digits  input  4*NUM_DIGITS  hex nibbles; digit i = digits[4i+3:4i]; digit 0 is least significant and rightmost.
- blank  input  NUM_DIGITS  1 = digit forced dark (segments and DP).
- dp_in  input  NUM_DIGITS  1 = decimal point lit for that digit.
- lz_suppress  input  1  level; 1 = blank leading zeros.
- CATHODE  output  7  active-low segments {g,f,e,d,c,b,a}.
- DP  output  1  active-low decimal point.
- ANODE  output  NUM_DIGITS  active-low digit enables; at most one bit low.

## Operation
- Shadow registers: sh_digits, sh_blank, sh_dp. All are 0 at reset and written only on a clock edge with load=1 and reset=0. Between loads, input changes have no effect.
- Slot counter cnt counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and the digit index idx advances. idx wraps from NUM_DIGITS-1 to 0. Scan order is 0,1,…,N-1.
- A digit is "dark" in any of these cases:
  - sh_blank[idx]=1.
  - cnt < GHOST_CYCLES.
  - Leading-zero suppression applies: lz_suppress=1, idx>0, and sh_digits for idx and every higher digit are all 0.
- Digit 0 is never zero-suppressed.
- Dark digit outputs: ANODE all ones, CATHODE 7'h7F, DP 1.
- Lit digit outputs: ANODE has only bit idx low. CATHODE = hex_to_seg(sh_digits[idx]). DP = ~sh_dp[idx].
- Segment map, active-low {g..a}:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78,
  - 8 = 00, 9 = 10, A = 08, b = 03, C = 27, d = 21, E = 04, F = 0E (hex values).
- lz_suppress is not shadowed; it takes effect live.

## Timing
- Reset is synchronous and is the only initialisation. While reset=1, every edge forces:
  - cnt=0, idx=0, shadows=0.
  - ANODE all ones, CATHODE 7'h7F, DP=1.
- Reset asserted mid-scan or mid-load aborts immediately; load is ignored on reset edges.
- CATHODE, DP and ANODE are registered. Each edge computes them from the pre-edge idx, cnt, shadows and lz_suppress, so outputs lag the counters by one cycle.
- The first edge after reset release outputs the state for idx=0, cnt=0. That is dark if GHOST_CYCLES>0.
- Load latency: load sampled at edge k means the new values appear on the outputs from edge k+1 onward. This applies only if the current digit is lit at that point.
- Frame period: NUM_DIGITS*REFRESH_DIV cycles. Per slot, each digit is lit for REFRESH_DIV-GHOST_CYCLES cycles.
- There is never an edge on which two ANODE bits are low. There is never an edge on which ANODE changes from one low bit directly to another unless GHOST_CYCLES=0.

## Structure
- Package seg7_pkg holds:
  - the 16-entry segment constant table;
  - function hex_to_seg(logic [3:0]) returning logic [6:0];
  - SEG_OFF = 7'h7F;
  - a typedef for the 7-bit segment vector.
- Counter widths are $clog2(REFRESH_DIV) and $clog2(NUM_DIGITS), minimum 1 bit.
- One sub-module: seg7_lz_mask. It is combinational and maps sh_digits plus lz_suppress to a NUM_DIGITS suppress mask.
- Scan counters, shadows and output registers live in the top.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, GHOST_CYCLES=2.
1. Reset: hold reset 3 cycles mid-scan → ANODE=4'hF, CATHODE=7'h7F, DP=1 on every reset edge. After release, ANODE stays F for 2 edges, then 4'hE with CATHODE=7'h40.
2. Scan order: load digits=16'h3A91, no blank/dp → ANODE cycles E,D,B,7, each low for 6 edges after 2 dark edges. CATHODE = 79,10,08,30 respectively. Frame is 32 cycles.
3. Shadowing: load 16'h1234, then change digits to 16'hFFFF without load → displayed values stay 4,3,2,1. Pulse load → next lit edge shows F.
4. Leading zeros: load 16'h0050, lz_suppress=1 → digits 3 and 2 dark (ANODE F during their slots); digit 1 shows 12; digit 0 shows 40. With 16'h0000, only digit 0 lit with 40.
5. Blank/DP: blank=4'b0100, dp_in=4'b0010 → digit 2 slot fully dark; DP=0 only while ANODE=4'hD.
6. Invariant: random loads, lz_suppress toggles and resets for 10k cycles → ANODE always all-ones or exactly one zero, and never one-hot to one-hot on consecutive edges.
